// File: rtl/program_counter_stack.sv
// Program counter with a LIFO hardware return stack for the fetch stage.
// Optional relative branch (rel/relOffset ports) is enabled by defining PC_REL_BRANCH_EN.
module program_counter_stack #(
  parameter int               WIDTH       = 12,
  parameter int               DEPTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enabled,
  input  logic                       load,
  input  logic                       call,
  input  logic                       ret,
  input  logic [WIDTH-1:0]           loadData,
`ifdef PC_REL_BRANCH_EN
  input  logic                       rel,
  input  logic [WIDTH-1:0]           relOffset,
`endif
  output logic [WIDTH-1:0]           outValue,
  output logic [$clog2(DEPTH+1)-1:0] stackDepth,
  output logic                       stackFull,
  output logic                       stackEmpty,
  output logic                       stackErr,
  output logic                       wrapped
);

  localparam int DW    = $clog2(DEPTH+1);
  // Stack storage is sized to the full depth-counter range so the counter indexes it directly.
  localparam int SLOTS = 1 << DW;

  function automatic logic [WIDTH-1:0] pc_inc(input logic [WIDTH-1:0] pc);
    return pc + WIDTH'(1);
  endfunction

`ifdef PC_REL_BRANCH_EN
  function automatic logic [WIDTH-1:0] pc_rel(input logic [WIDTH-1:0] pc,
                                               input logic [WIDTH-1:0] off);
    logic signed [WIDTH-1:0] soff;
    logic signed [WIDTH-1:0] spc;
    soff = $signed(off);
    spc  = $signed(pc);
    return $unsigned(spc + soff);
  endfunction
`endif

  logic [WIDTH-1:0] pc_p0, pc_nxt;
  logic [DW-1:0]    depth_p0, depth_nxt, top_idx;
  logic             full_p0, empty_p0, err_p0, wrap_p0;
  logic             err_nxt, wrap_nxt, push;
  logic [WIDTH-1:0] stack_p0 [SLOTS];

  assign top_idx = depth_p0 - DW'(1);

  always_comb begin
    pc_nxt    = pc_p0;
    depth_nxt = depth_p0;
    err_nxt   = err_p0;
    wrap_nxt  = 1'b0;
    push      = 1'b0;
    if (load) begin
      pc_nxt = loadData;
    end else if (call) begin
      if (!full_p0) begin
        push      = 1'b1;
        depth_nxt = depth_p0 + DW'(1);
        pc_nxt    = loadData;
      end else begin
        err_nxt = 1'b1;
      end
    end else if (ret) begin
      if (!empty_p0) begin
        depth_nxt = top_idx;
        pc_nxt    = stack_p0[top_idx];
      end else begin
        err_nxt = 1'b1;
      end
`ifdef PC_REL_BRANCH_EN
    end else if (rel) begin
      pc_nxt = pc_rel(pc_p0, relOffset);
`endif
    end else if (enabled) begin
      pc_nxt   = pc_inc(pc_p0);
      wrap_nxt = &pc_p0;
    end
  end

  // Stage p0: architectural state and registered status flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_p0    <= RESET_VALUE;
      depth_p0 <= '0;
      full_p0  <= 1'b0;
      empty_p0 <= 1'b1;
      err_p0   <= 1'b0;
      wrap_p0  <= 1'b0;
    end else begin
      pc_p0    <= pc_nxt;
      depth_p0 <= depth_nxt;
      full_p0  <= (depth_nxt == DW'(DEPTH));
      empty_p0 <= (depth_nxt == '0);
      err_p0   <= err_nxt;
      wrap_p0  <= wrap_nxt;
    end
  end

  // Return addresses are plain data: no reset, contents are don't-care while unused.
  always_ff @(posedge clk) begin
    if (push) stack_p0[depth_p0] <= pc_inc(pc_p0);
  end

  assign outValue   = pc_p0;
  assign stackDepth = depth_p0;
  assign stackFull  = full_p0;
  assign stackEmpty = empty_p0;
  assign stackErr   = err_p0;
  assign wrapped    = wrap_p0;

endmodule

// File: tb/tb_program_counter_stack.sv
// Self-checking bench for program_counter_stack using a queue-based reference model.
module tb_program_counter_stack;
  localparam int WIDTH = 12;
  localparam int DEPTH = 4;
  localparam int DW    = $clog2(DEPTH+1);
  localparam int M     = 1 << WIDTH;

  logic clk = 1'b0, reset = 1'b1;
  logic enabled = 0, load = 0, call = 0, ret = 0, rel = 0;
  logic [WIDTH-1:0] loadData = '0, relOffset = '0;
  logic [WIDTH-1:0] outValue;
  logic [DW-1:0]    stackDepth;
  logic stackFull, stackEmpty, stackErr, wrapped;

  program_counter_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VALUE('0)) dut (
    .clk(clk), .reset(reset), .enabled(enabled), .load(load), .call(call),
    .ret(ret), .loadData(loadData),
`ifdef PC_REL_BRANCH_EN
    .rel(rel), .relOffset(relOffset),
`endif
    .outValue(outValue), .stackDepth(stackDepth), .stackFull(stackFull),
    .stackEmpty(stackEmpty), .stackErr(stackErr), .wrapped(wrapped)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;
  int m_pc;
  int m_q[$];
  bit m_err, m_wrap;

  logic [WIDTH+DW+3:0] dv;
  assign dv = {outValue, stackDepth, stackFull, stackEmpty, stackErr, wrapped};

  function automatic logic [WIDTH+DW+3:0] exp_vec();
    return {WIDTH'(m_pc), DW'(m_q.size()), m_q.size() == DEPTH, m_q.size() == 0, m_err, m_wrap};
  endfunction

  function automatic void model_reset();
    m_pc = 0; m_q.delete(); m_err = 0; m_wrap = 0;
  endfunction

  function automatic void model_step(bit ld, bit cl, bit rt, bit rl, bit en, int d, int off);
    int soff;
    m_wrap = 0;
    if (ld) m_pc = d;
    else if (cl) begin
      if (m_q.size() < DEPTH) begin m_q.push_back((m_pc + 1) % M); m_pc = d; end
      else m_err = 1;
    end else if (rt) begin
      if (m_q.size() > 0) m_pc = m_q.pop_back();
      else m_err = 1;
`ifdef PC_REL_BRANCH_EN
    end else if (rl) begin
      soff = (off >= M/2) ? off - M : off;
      m_pc = ((m_pc + soff) % M + M) % M;
`endif
    end else if (en) begin
      m_wrap = (m_pc == M - 1);
      m_pc = (m_pc + 1) % M;
    end
  endfunction

  task automatic step(input bit ld, input bit cl, input bit rt, input bit rl, input bit en,
                      input int d, input int off);
    logic [31:0] dd, oo;
    dd = d; oo = off;
    load = ld; call = cl; ret = rt; rel = rl; enabled = en;
    loadData = dd[WIDTH-1:0]; relOffset = oo[WIDTH-1:0];
    @(posedge clk); #1;
`ifdef PC_REL_BRANCH_EN
    model_step(ld, cl, rt, rl, en, d, off);
`else
    model_step(ld, cl, rt, 1'b0, en, d, off);
`endif
    load = 0; call = 0; ret = 0; rel = 0; enabled = 0;
  endtask

  task automatic do_reset();
    reset = 1; @(posedge clk); #1; reset = 0; model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (dv !== exp_vec()) begin miscompares++; $display("FAIL reset: got %h expected %h", dv, exp_vec()); end
  endtask

  task automatic test_increment();
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 1, 0, 0);
      vectors++;
      if (dv !== exp_vec() || outValue !== WIDTH'(i + 1) || stackEmpty !== 1'b1) begin
        miscompares++; $display("FAIL increment[%0d]: got %h expected %h", i, dv, exp_vec());
      end
    end
  endtask

  task automatic test_call_ret();
    step(1, 0, 0, 0, 0, 'h010, 0);
    step(0, 1, 0, 0, 0, 'h200, 0);
    vectors++;
    if (dv !== exp_vec() || outValue !== 12'h200 || stackDepth !== DW'(1)) begin
      miscompares++; $display("FAIL call: got %h expected %h", dv, exp_vec());
    end
    step(0, 0, 1, 0, 0, 0, 0);
    vectors++;
    if (dv !== exp_vec() || outValue !== 12'h011 || stackDepth !== DW'(0)) begin
      miscompares++; $display("FAIL ret: got %h expected %h", dv, exp_vec());
    end
  endtask

  task automatic test_nested();
    do_reset();
    for (int i = 0; i < DEPTH + 1; i++) begin
      step(0, 1, 0, 0, 0, $urandom_range(M - 1), 0);
      vectors++;
      if (dv !== exp_vec()) begin miscompares++; $display("FAIL nested_call[%0d]: got %h expected %h", i, dv, exp_vec()); end
    end
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 0, 1, 0, 0, 0, 0);
      vectors++;
      if (dv !== exp_vec()) begin miscompares++; $display("FAIL nested_ret[%0d]: got %h expected %h", i, dv, exp_vec()); end
    end
    vectors++;
    if (outValue !== 12'h001 || stackErr !== 1'b1) begin
      miscompares++; $display("FAIL nested_unwind: got pc %h err %b expected pc 001 err 1", outValue, stackErr);
    end
  endtask

  task automatic test_underflow();
    do_reset();
    step(1, 0, 0, 0, 0, 'h345, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    vectors++;
    if (dv !== exp_vec() || outValue !== 12'h345 || stackErr !== 1'b1) begin
      miscompares++; $display("FAIL underflow: got %h expected %h", dv, exp_vec());
    end
    for (int i = 0; i < 6; i++) begin
      step(0, i % 2, (i % 3) == 0, 0, 1, $urandom_range(M - 1), 0);
      vectors++;
      if (dv !== exp_vec()) begin miscompares++; $display("FAIL err_sticky[%0d]: got %h expected %h", i, dv, exp_vec()); end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    step(1, 0, 0, 0, 0, 'hFFF, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    vectors++;
    if (dv !== exp_vec() || outValue !== 12'h000 || wrapped !== 1'b1) begin
      miscompares++; $display("FAIL wrap: got %h expected %h", dv, exp_vec());
    end
    step(0, 0, 0, 0, 0, 0, 0);
    vectors++;
    if (dv !== exp_vec() || wrapped !== 1'b0) begin miscompares++; $display("FAIL wrap_pulse: got %h expected %h", dv, exp_vec()); end
    step(1, 1, 0, 0, 1, 'h0AB, 0);
    vectors++;
    if (dv !== exp_vec() || outValue !== 12'h0AB || stackDepth !== DW'(0)) begin
      miscompares++; $display("FAIL priority: got %h expected %h", dv, exp_vec());
    end
    step(1, 0, 0, 0, 0, 'hFFF, 0);
    step(0, 1, 0, 0, 0, 'h123, 0);
    step(0, 0, 1, 0, 1, 0, 0);
    vectors++;
    if (dv !== exp_vec() || outValue !== 12'h000 || wrapped !== 1'b0) begin
      miscompares++; $display("FAIL call_wrap_ret: got %h expected %h", dv, exp_vec());
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    step(0, 1, 0, 0, 0, 'h111, 0);
    step(0, 1, 0, 0, 0, 'h222, 0);
    #3; reset = 1; #1;
    model_reset();
    vectors++;
    if (dv !== exp_vec()) begin miscompares++; $display("FAIL async_reset: got %h expected %h", dv, exp_vec()); end
    @(negedge clk); reset = 0;
    step(0, 0, 1, 0, 0, 0, 0);
    vectors++;
    if (dv !== exp_vec()) begin miscompares++; $display("FAIL post_reset_ret: got %h expected %h", dv, exp_vec()); end
  endtask

`ifdef PC_REL_BRANCH_EN
  task automatic test_rel();
    do_reset();
    step(1, 0, 0, 0, 0, 'h100, 0);
    step(0, 0, 0, 1, 1, 0, 'hFFE);
    vectors++;
    if (dv !== exp_vec() || outValue !== 12'h0FE || wrapped !== 1'b0) begin
      miscompares++; $display("FAIL rel: got %h expected %h", dv, exp_vec());
    end
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 0, 1, $urandom_range(1), 0, $urandom_range(M - 1));
      vectors++;
      if (dv !== exp_vec()) begin miscompares++; $display("FAIL rel_rand[%0d]: got %h expected %h", i, dv, exp_vec()); end
    end
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(9) == 0, $urandom_range(4) == 0, $urandom_range(4) == 0,
           $urandom_range(5) == 0, $urandom_range(1), $urandom_range(M - 1), $urandom_range(M - 1));
      vectors++;
      if (dv !== exp_vec()) begin miscompares++; $display("FAIL random[%0d]: got %h expected %h", i, dv, exp_vec()); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_increment();
    test_call_ret();
    test_nested();
    test_underflow();
    test_wrap();
    test_async_reset();
`ifdef PC_REL_BRANCH_EN
    test_rel();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
